// File: rtl/arbiter.sv
// arbiter
//
// Fixed-priority, sequential-service request arbiter. When idle, the arbiter
// captures a snapshot of `request`. Every requester in the snapshot then gets
// exactly one single-cycle grant, one per cycle, in ascending bit order.
// Bit 0 has the highest priority. While the snapshot is being drained, `stall`
// is high and `request` is not sampled.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_b  in   asynchronous active-low reset
//   request  in   [N-1:0] request vector, sampled only while stall = 0
//   grant    out  [N-1:0] registered grant, one-hot or zero
//   stall    out  registered, high while snapshot still has ungranted bits
module arbiter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [N-1:0] request,
    output logic [N-1:0] grant,
    output logic         stall
);

    localparam logic [N-1:0] One = N'(1);

    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic [N-1:0] grant_d;
    logic         stall_d;
    logic [N-1:0] src;

    always_comb begin
        // Draining works from the stored snapshot; idle works from the live request.
        src       = stall ? pending_q : request;
        // Two's-complement trick isolates the lowest set bit.
        grant_d   = src & (~src + One);
        pending_d = src & ~grant_d;
        stall_d   = |pending_d;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pending_q <= '0;
            grant     <= '0;
            stall     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            grant     <= grant_d;
            stall     <= stall_d;
        end
    end

endmodule

// File: tb/tb_arbiter.sv
// tb_arbiter
//
// Scoreboard bench for arbiter. The stimulus process drives `request` at each
// falling edge and runs a list-based reference model: when the model is idle
// it captures the set bits of the request as a list of indices; each cycle it
// grants the head of the list. The expected {grant, stall} is queued; a
// separate monitor pops and compares just after each rising edge.
module tb_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_b = 1'b0;
    logic [N-1:0] request = '0;
    logic [N-1:0] grant;
    logic         stall;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N:0] exp_q[$];   // {grant, stall} expected after the next rising edge
    int         model_q[$]; // indices of snapshot requesters not yet granted

    arbiter #(.N(N)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .request (request),
        .grant   (grant),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Called at a falling edge: drive request, advance the model by one edge,
    // push the expectation, then move on to the next falling edge.
    task automatic step(input logic [N-1:0] r);
        logic [N-1:0] g;
        request = r;
        if (model_q.size() == 0) begin
            for (int i = 0; i < N; i++) begin
                if (r[i]) model_q.push_back(i);
            end
        end
        g = '0;
        if (model_q.size() > 0) g[model_q.pop_front()] = 1'b1;
        exp_q.push_back({g, model_q.size() != 0});
        @(negedge clk);
    endtask

    // Monitor
    initial begin
        logic [N:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", grant, e[N:1]);
                check("stall", {{(N-1){1'b0}}, stall}, {{(N-1){1'b0}}, e[0]});
                check("onehot", {{(N-1){1'b0}}, ($countones(grant) <= 1)}, {{(N-1){1'b0}}, 1'b1});
            end
        end
    end

    initial begin
        // Reset held with all requests asserted
        reset_b = 1'b0;
        request = 8'hFF;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_grant", grant, '0);
            check("reset_stall", {{(N-1){1'b0}}, stall}, '0);
        end

        // Release; first edge samples 0xFF, then full drain with early drop
        @(negedge clk);
        reset_b = 1'b1;
        step(8'hFF);
        repeat (9) step(8'h00);

        // Two-bit snapshot
        step(8'h24);
        repeat (3) step(8'h00);

        // Single and zero requests
        step(8'h10);
        repeat (3) step(8'h00);

        // Changes during a drain are ignored; 0x7E sampled after stall falls
        step(8'h81);
        step(8'h7E);
        step(8'h7E);
        repeat (7) step(8'h00);

        // Reset asserted mid-drain discards the snapshot
        step(8'hFF);
        step(8'h00);
        step(8'h00);
        @(posedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        check("midreset_grant", grant, '0);
        check("midreset_stall", {{(N-1){1'b0}}, stall}, '0);
        model_q.delete();
        @(negedge clk);
        reset_b = 1'b1;
        step(8'h06);
        repeat (3) step(8'h00);

        // Random chain, with random junk driven during drains
        for (int k = 0; k < 60; k++) begin
            step(N'($urandom()));
        end
        repeat (10) step(8'h00);

        // Every queued expectation must have been consumed
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
